// File: rtl/alu_ex_unit_pkg.sv
// Shared definitions for the EX-stage execute unit: widths, ALU control codes
// (the same codes ALU control emits), FSM state type and the single-cycle op decode.
package alu_ex_unit_pkg;

  localparam int XLEN      = 32;
  localparam int MUL_STEPS = XLEN;
  localparam int SHW       = $clog2(XLEN);
  localparam int CNTW      = $clog2(MUL_STEPS);

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_XOR  = 4'b0001;
  localparam logic [3:0] ALU_SLL  = 4'b0010;
  localparam logic [3:0] ALU_ADD  = 4'b0011;
  localparam logic [3:0] ALU_SUB  = 4'b0100;
  localparam logic [3:0] ALU_MUL  = 4'b0101;
  localparam logic [3:0] ALU_ADDI = 4'b0110;
  localparam logic [3:0] ALU_SRAI = 4'b0111;
  localparam logic [3:0] ALU_LW   = 4'b1000;
  localparam logic [3:0] ALU_SW   = 4'b1001;
  localparam logic [3:0] ALU_BEQ  = 4'b1010;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } ex_state_e;

  // MUL yields 0 here: its product only ever comes from the iterative datapath,
  // so no wide combinational multiplier is built.
  function automatic logic [XLEN-1:0] alu_comb(input logic [3:0]      ctrl,
                                               input logic [XLEN-1:0] a,
                                               input logic [XLEN-1:0] b);
    logic [SHW-1:0]         sh;
    logic signed [XLEN-1:0] sa;
    logic [XLEN-1:0]        r;
    sh = b[SHW-1:0];
    sa = a;
    r  = '0;
    case (ctrl)
      ALU_AND:                         r = a & b;
      ALU_XOR:                         r = a ^ b;
      ALU_SLL:                         r = a << sh;
      ALU_ADD, ALU_ADDI, ALU_LW, ALU_SW: r = a + b;
      ALU_SUB, ALU_BEQ:                r = a - b;
      ALU_SRAI:                        r = sa >>> sh;
      default:                         r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/alu_ex_unit_if.sv
// EX-stage operand/result bundle between the pipeline (master) and the execute unit (slave).
interface alu_ex_unit_if;
  import alu_ex_unit_pkg::*;

  logic            valid_i;
  logic [3:0]      ALUCtrl_i;
  logic [XLEN-1:0] data1_i;
  logic [XLEN-1:0] data2_i;
  logic            mem_stall_i;
  logic [XLEN-1:0] result_o;
  logic            zero_o;
  logic            stall_o;

  modport master (output valid_i, ALUCtrl_i, data1_i, data2_i, mem_stall_i,
                  input  result_o, zero_o, stall_o);
  modport slave  (input  valid_i, ALUCtrl_i, data1_i, data2_i, mem_stall_i,
                  output result_o, zero_o, stall_o);
endinterface

// File: rtl/alu_ex_unit_mul_iter.sv
// mul_iter: shift-add multiplier datapath with step counter; one partial
// product per clock, low XLEN bits of the product kept in the accumulator.
module alu_ex_unit_mul_iter
  import alu_ex_unit_pkg::*;
(
  input  logic            clk_i,
  input  logic            rst_n_i,
  input  logic            start_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  output logic            busy_o,
  output logic            done_pulse_o,
  output logic [XLEN-1:0] prod_o
);

  logic [XLEN-1:0] mcand_q, mcand_d;
  logic [XLEN-1:0] mplier_q, mplier_d;
  logic [XLEN-1:0] acc_q, acc_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic            busy_q, busy_d;
  logic            last_step;

  assign last_step = busy_q && (cnt_q == CNTW'(MUL_STEPS - 1));

  always_comb begin
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    if (start_i) begin
      mcand_d  = a_i;
      mplier_d = b_i;
      acc_d    = '0;
      cnt_d    = '0;
      busy_d   = 1'b1;
    end else if (busy_q) begin
      acc_d    = acc_q + (mplier_q[0] ? mcand_q : '0);
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + CNTW'(1);
      if (last_step) busy_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
    end else begin
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
    end
  end

  assign busy_o       = busy_q;
  assign done_pulse_o = last_step;
  assign prod_o       = acc_q;

endmodule

// File: rtl/alu_ex_unit.sv
// EX-stage execute unit: single-cycle ALU ops plus an iterative MUL that
// freezes the front of the pipeline through stall_o while it runs.
//   state | meaning
//   IDLE  | result is the combinational op; a valid MUL is accepted here
//   BUSY  | shift-add iterations in flight, pipeline held, result 0
//   DONE  | product presented; held while memory freezes the pipeline
module alu_ex_unit
  import alu_ex_unit_pkg::*;
(
  input  logic         clk_i,
  input  logic         rst_n_i,
  alu_ex_unit_if.slave ex
);

  ex_state_e       state_q, state_d;
  logic            mul_start;
  logic            mul_busy;
  logic            mul_done;
  logic [XLEN-1:0] mul_prod;
  logic [XLEN-1:0] comb_res;
  logic [XLEN-1:0] result;
  logic            stall;

  assign comb_res  = alu_comb(ex.ALUCtrl_i, ex.data1_i, ex.data2_i);
  assign mul_start = (state_q == ST_IDLE) && ex.valid_i && (ex.ALUCtrl_i == ALU_MUL);

  alu_ex_unit_mul_iter u_mul_iter (
    .clk_i       (clk_i),
    .rst_n_i     (rst_n_i),
    .start_i     (mul_start),
    .a_i         (ex.data1_i),
    .b_i         (ex.data2_i),
    .busy_o      (mul_busy),
    .done_pulse_o(mul_done),
    .prod_o      (mul_prod)
  );

  always_comb begin
    state_d = state_q;
    stall   = 1'b0;
    result  = comb_res;
    case (state_q)
      ST_IDLE: begin
        if (mul_start) begin
          stall   = 1'b1;
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        stall  = mul_busy;
        result = '0;
        if (mul_done) state_d = ST_DONE;
      end
      ST_DONE: begin
        result = mul_prod;
        if (!ex.mem_stall_i) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  assign ex.result_o = result;
  assign ex.zero_o   = (result == '0);
  assign ex.stall_o  = stall;

endmodule

// File: tb/tb_alu_ex_unit.sv
// Directed + randomized bench for alu_ex_unit against an arithmetic reference model.
module tb_alu_ex_unit;
  import alu_ex_unit_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  int   n_assert = 0;
  int   n_fail   = 0;

  alu_ex_unit_if ex();

  alu_ex_unit dut (
    .clk_i  (clk),
    .rst_n_i(rst_n),
    .ex     (ex)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] model_alu(input logic [3:0] code,
                                            input logic [31:0] a,
                                            input logic [31:0] b);
    logic [63:0]        p;
    logic signed [31:0] sa;
    int                 sh;
    sh = int'(b % 32);
    sa = a;
    p  = {32'd0, a} * {32'd0, b};
    case (code)
      4'd0:                 return a & b;
      4'd1:                 return a ^ b;
      4'd2:                 return a << sh;
      4'd3, 4'd6, 4'd8, 4'd9: return a + b;
      4'd4, 4'd10:          return a - b;
      4'd5:                 return p[31:0];
      4'd7:                 return sa >>> sh;
      default:              return 32'd0;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [3:0] code,
                       input logic [31:0] a, input logic [31:0] b);
    ex.valid_i   = v;
    ex.ALUCtrl_i = code;
    ex.data1_i   = a;
    ex.data2_i   = b;
  endtask

  task automatic check_comb(input string tag);
    logic [31:0] e;
    #1;
    e = model_alu(ex.ALUCtrl_i, ex.data1_i, ex.data2_i);
    chk({tag, "_result"}, ex.result_o, e);
    chk({tag, "_zero"}, 32'(ex.zero_o), 32'(e == 32'd0));
    chk({tag, "_stall"}, 32'(ex.stall_o), 32'd0);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Called at posedge+1 with the FSM in IDLE; returns in DONE with mem_stall_i=0.
  task automatic run_mul(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input int hold);
    logic [31:0] e;
    int          stall_cnt;
    int          n;
    bit          done;
    e = model_alu(4'd5, a, b);
    drive(1'b1, 4'd5, a, b);
    ex.mem_stall_i = 1'b0;
    #1;
    chk({tag, "_accept_stall"}, 32'(ex.stall_o), 32'd1);
    stall_cnt = 1;
    n    = 0;
    done = 1'b0;
    while (!done && n < 40) begin
      @(posedge clk);
      #1;
      drive(1'b0, 4'($urandom_range(0, 15)), $urandom, $urandom);
      ex.mem_stall_i = 1'($urandom_range(0, 1));
      #1;
      if (ex.stall_o) stall_cnt++;
      else done = 1'b1;
      n++;
    end
    chk({tag, "_finished"}, 32'(done), 32'd1);
    chk({tag, "_stall_cycles"}, 32'(stall_cnt), 32'd33);
    ex.mem_stall_i = (hold > 0);
    #1;
    chk({tag, "_product"}, ex.result_o, e);
    chk({tag, "_zero"}, 32'(ex.zero_o), 32'(e == 32'd0));
    for (int i = 0; i < hold; i++) begin
      ex.mem_stall_i = 1'b1;
      drive(1'b1, 4'd5, $urandom, $urandom);
      @(posedge clk);
      #2;
      chk({tag, "_held_result"}, ex.result_o, e);
      chk({tag, "_held_nostall"}, 32'(ex.stall_o), 32'd0);
    end
    ex.mem_stall_i = 1'b0;
  endtask

  initial begin
    logic [31:0] a, b;
    logic [3:0]  code;

    rst_n = 1'b0;
    ex.mem_stall_i = 1'b0;
    drive(1'b1, 4'd3, 32'd5, 32'd7);
    #3;
    chk("reset_add_result", ex.result_o, 32'd12);
    chk("reset_stall", 32'(ex.stall_o), 32'd0);
    #10 rst_n = 1'b1;
    next_cycle();

    drive(1'b1, 4'd3, 32'd5, 32'd7);           check_comb("add_5_7");
    chk("add_5_7_const", ex.result_o, 32'd12);
    next_cycle(); drive(1'b1, 4'd10, 32'd9, 32'd9);  check_comb("beq_9_9");
    chk("beq_zero_const", 32'(ex.zero_o), 32'd1);
    next_cycle(); drive(1'b1, 4'd4, 32'd3, 32'd5);   check_comb("sub_3_5");
    chk("sub_const", ex.result_o, 32'hFFFF_FFFE);
    next_cycle(); drive(1'b1, 4'd7, 32'h8000_0000, 32'd4); check_comb("srai");
    chk("srai_const", ex.result_o, 32'hF800_0000);
    next_cycle(); drive(1'b1, 4'd2, 32'd1, 32'd31);  check_comb("sll");
    chk("sll_const", ex.result_o, 32'h8000_0000);
    next_cycle(); drive(1'b1, 4'd13, 32'd1, 32'd2);  check_comb("undef_code");

    for (int i = 0; i < 40; i++) begin
      next_cycle();
      code = 4'($urandom_range(0, 15));
      if (code == 4'd5) code = 4'd3;
      a = $urandom;
      b = ($urandom_range(0, 3) == 0) ? a : $urandom;
      drive(1'($urandom_range(0, 1)), code, a, b);
      ex.mem_stall_i = 1'($urandom_range(0, 1));
      check_comb("rand_op");
    end
    ex.mem_stall_i = 1'b0;

    next_cycle();
    drive(1'b0, 4'd5, 32'd6, 32'd7);
    #1;
    chk("bubble_mul_nostall", 32'(ex.stall_o), 32'd0);
    next_cycle();
    drive(1'b1, 4'd3, 32'd20, 32'd22);
    check_comb("bubble_stays_idle");

    next_cycle(); run_mul("mul_6_7", 32'd6, 32'd7, 0);
    chk("mul_6_7_const", ex.result_o, 32'd42);
    next_cycle(); drive(1'b1, 4'd3, 32'd5, 32'd7); check_comb("after_mul_idle");

    next_cycle(); run_mul("mul_neg1_2", 32'hFFFF_FFFF, 32'd2, 0);
    chk("mul_neg1_2_const", ex.result_o, 32'hFFFF_FFFE);
    next_cycle(); run_mul("mul_b2b", 32'h1234_5678, 32'h9ABC_DEF1, 0);
    next_cycle(); run_mul("mul_ovf", 32'h0001_0000, 32'h0001_0000, 0);
    chk("mul_ovf_zero_const", 32'(ex.zero_o), 32'd1);
    next_cycle(); drive(1'b0, 4'd0, 32'd0, 32'd0); check_comb("gap");

    next_cycle(); run_mul("mul_memstall", 32'd123, 32'd456, 3);
    next_cycle(); drive(1'b1, 4'd1, 32'hF0F0_F0F0, 32'h0FF0_0FF0);
    check_comb("memstall_then_idle");

    for (int i = 0; i < 3; i++) begin
      next_cycle();
      run_mul("mul_rand", $urandom, $urandom, int'($urandom_range(0, 2)));
    end

    next_cycle();
    drive(1'b1, 4'd5, 32'd11, 32'd13);
    repeat (10) @(posedge clk);
    #1;
    drive(1'b1, 4'd3, 32'd1, 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_mid_mul_stall", 32'(ex.stall_o), 32'd0);
    chk("rst_mid_mul_result", ex.result_o, 32'd2);
    #1 rst_n = 1'b1;
    next_cycle();
    check_comb("post_reset_add");
    chk("post_reset_add_const", ex.result_o, 32'd2);
    next_cycle();
    check_comb("post_reset_add2");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
